// File: rtl/cache_arbiter.sv
// Two-client arbiter sharing one line-wide memory port between I-cache and D-cache.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise D-cache wins ties.
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       i_req;
    logic       d_req;
    logic       grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie, the client that did not win last time gets the port.
    assign grant_d = d_req & (~i_req | ~last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && (i_req | d_req)) begin
            last_grant <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = SERVE_D;
                end else if (i_req) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I: begin
                if (mem_resp || !i_req) begin
                    state_next = IDLE;
                end
            end
            SERVE_D: begin
                if (mem_resp || !d_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory-side outputs follow the granted client's live inputs only.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        case (state)
            SERVE_I: begin
                mem_read    = i_pmem_read;
                mem_address = i_pmem_address;
            end
            SERVE_D: begin
                mem_write   = d_pmem_write;
                mem_read    = d_pmem_read & ~d_pmem_write;
                mem_address = d_pmem_address;
                mem_wdata   = d_pmem_wdata;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;
    assign i_pmem_resp  = mem_resp & (state == SERVE_I);
    assign d_pmem_resp  = mem_resp & (state == SERVE_D);

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: ownership model plus directed scenarios and random traffic.
// Follows ARB_ROUND_ROBIN_EN to select the expected tie-break rule.
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_resp = 1'b0;

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    // Clock/reset block
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the memory port (0 none, 1 I-cache, 2 D-cache).
    int owner  = 0;
    bit m_last = 1'b1;

    always @(posedge clk) begin
        bit ireq;
        bit dreq;
        int winner;
        ireq = i_pmem_read;
        dreq = d_pmem_read | d_pmem_write;
        if (rst) begin
            owner  = 0;
            m_last = 1'b1;
        end else if (owner == 0) begin
            if (ireq || dreq) begin
                if (ireq && dreq) winner = RR ? (m_last ? 1 : 2) : 2;
                else winner = ireq ? 1 : 2;
                owner  = winner;
                m_last = (winner == 2);
            end
        end else if (mem_resp || (owner == 1 ? !ireq : !dreq)) begin
            owner = 0;
        end
    end

    // Scoreboard: expected response data queued when the model predicts a response.
    logic [LW-1:0] exp_q[$];
    logic          e_read, e_write, e_iresp, e_dresp;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_read = 1'b0; e_write = 1'b0; e_addr = '0; e_wdata = '0;
            if (owner == 1) begin
                e_read = i_pmem_read;
                e_addr = i_pmem_address;
            end else if (owner == 2) begin
                e_write = d_pmem_write;
                e_read  = d_pmem_read && !d_pmem_write;
                e_addr  = d_pmem_address;
                e_wdata = d_pmem_wdata;
            end
            e_iresp = mem_resp && owner == 1;
            e_dresp = mem_resp && owner == 2;
            check("mem_read", LW'(mem_read), LW'(e_read));
            check("mem_write", LW'(mem_write), LW'(e_write));
            check("mem_address", LW'(mem_address), LW'(e_addr));
            check("mem_wdata", mem_wdata, e_wdata);
            check("i_resp", LW'(i_pmem_resp), LW'(e_iresp));
            check("d_resp", LW'(d_pmem_resp), LW'(e_dresp));
            check("i_rdata", i_pmem_rdata, mem_rdata);
            check("d_rdata", d_pmem_rdata, mem_rdata);
            if (e_iresp || e_dresp) exp_q.push_back(mem_rdata);
            if (i_pmem_resp || d_pmem_resp) begin
                if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
                else check("resp_data", i_pmem_resp ? i_pmem_rdata : d_pmem_rdata, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0;
        mem_resp = 1'b0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cmp_en = 1'b1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [AW-1:0] tie_exp[3];

        // Reset state
        reset_dut();
        @(negedge clk);
        check("reset_read", LW'(mem_read), 0);
        check("reset_addr", LW'(mem_address), 0);

        // I-only fill
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
        tick();
        @(negedge clk);
        check("ionly_read", LW'(mem_read), 1);
        check("ionly_addr", LW'(mem_address), LW'(32'h0000_1000));
        repeat (4) tick();
        mem_rdata = {32{8'hAA}}; mem_resp = 1'b1;
        @(negedge clk);
        check("ionly_resp", LW'(i_pmem_resp), 1);
        check("ionly_rdata", i_pmem_rdata, {32{8'hAA}});
        tick();
        mem_resp = 1'b0; i_pmem_read = 1'b0;
        @(negedge clk);
        check("ionly_idle", LW'(mem_read), 0);

        // D write-back, then fill
        tick();
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2000; d_pmem_wdata = {32{8'h55}};
        tick();
        @(negedge clk);
        check("wb_write", LW'(mem_write), 1);
        check("wb_wdata", mem_wdata, {32{8'h55}});
        d_pmem_read = 1'b1;
        @(negedge clk);
        check("both_write", LW'(mem_write), 1);
        check("both_read", LW'(mem_read), 0);
        tick();
        d_pmem_read = 1'b0;
        mem_resp = 1'b1;
        @(negedge clk);
        check("wb_resp", LW'(d_pmem_resp), 1);
        tick();
        mem_resp = 1'b0; d_pmem_write = 1'b0;
        d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000;
        @(negedge clk);
        check("gap_idle", LW'(mem_read | mem_write), 0);
        tick();
        @(negedge clk);
        check("fill_read", LW'(mem_read), 1);
        check("fill_addr", LW'(mem_address), LW'(32'h0000_3000));
        tick();
        mem_resp = 1'b1;
        @(negedge clk);
        check("fill_resp", LW'(d_pmem_resp), 1);
        tick();
        clear_inputs();

        // Tie from reset, three back-to-back grants
        reset_dut();
        i_pmem_read = 1'b1; i_pmem_address = 32'h40;
        d_pmem_read = 1'b1; d_pmem_address = 32'h80;
        tie_exp[0] = RR ? 32'h40 : 32'h80;
        tie_exp[1] = 32'h80;
        tie_exp[2] = RR ? 32'h40 : 32'h80;
        for (int k = 0; k < 3; k++) begin
            tick();
            mem_resp = 1'b1;
            @(negedge clk);
            check("tie_grant", LW'(mem_address), LW'(tie_exp[k]));
            tick();
            mem_resp = 1'b0;
        end
        clear_inputs();

        // D arrives while I is being served
        tick();
        i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        tick();
        d_pmem_read = 1'b1; d_pmem_address = 32'h200;
        repeat (2) tick();
        @(negedge clk);
        check("hold_addr", LW'(mem_address), LW'(32'h100));
        tick();
        mem_resp = 1'b1;
        @(negedge clk);
        check("hold_iresp", LW'(i_pmem_resp), 1);
        tick();
        mem_resp = 1'b0; i_pmem_read = 1'b0;
        @(negedge clk);
        check("hold_gap", LW'(mem_read), 0);
        tick();
        @(negedge clk);
        check("hold_dgrant", LW'(mem_address), LW'(32'h200));
        clear_inputs();
        tick();

        // Reset mid-transaction abandons it
        d_pmem_read = 1'b1; d_pmem_address = 32'h500;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        mem_resp = 1'b1;
        @(negedge clk);
        check("rst_dresp", LW'(d_pmem_resp), 0);
        check("rst_read", LW'(mem_read), 0);
        tick();
        rst = 1'b0; mem_resp = 1'b0; d_pmem_read = 1'b0;
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            i_pmem_read    = ($urandom_range(0, 3) != 0);
            d_pmem_read    = ($urandom_range(0, 2) == 0);
            d_pmem_write   = ($urandom_range(0, 3) == 0);
            i_pmem_address = $urandom;
            d_pmem_address = $urandom;
            d_pmem_wdata   = rand_line();
            mem_rdata      = rand_line();
            mem_resp       = ($urandom_range(0, 3) == 0);
            rst            = ($urandom_range(0, 99) == 0);
            tick();
        end
        clear_inputs();
        rst = 1'b0;
        repeat (2) tick();
        check("queue_empty", LW'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
